// File: rtl/dmem_bridge_if.sv
// Bus side of the data-memory bridge: request/address phase plus data-return phase.
// The bridge is the master; the memory is the slave.
interface dmem_bridge_if #(
    parameter int unsigned WIDTH = 32
);
    logic             data_req;
    logic             data_wr;
    logic [1:0]       data_size;
    logic [WIDTH-1:0] data_addr;
    logic [WIDTH-1:0] data_wdata;
    logic             data_addr_ok;
    logic             data_data_ok;
    logic [WIDTH-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// MEM-stage to split-transaction memory bus bridge: one outstanding access,
// registered bus fields, one-cycle done/err pulses and a pipeline stall.
module dmem_bridge #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cpu_en,
    input  logic [3:0]       cpu_wen,
    input  logic [1:0]       cpu_rsize,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_done,
    output logic             cpu_err,
    output logic             cpu_stall,
    dmem_bridge_if.master    bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e           state_q;
    logic             req_q;
    logic             wr_q;
    logic [1:0]       size_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic             done_q;
    logic             err_q;

    logic       wen_legal;
    logic [1:0] wen_size;

    // Only contiguous naturally aligned lanes are legal; 4'b0000 is a load.
    always_comb begin
        wen_legal = 1'b1;
        wen_size  = 2'd0;
        case (cpu_wen)
            4'b0000:                            wen_size = 2'd0;
            4'b1111:                            wen_size = 2'd2;
            4'b0011, 4'b1100:                   wen_size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_size = 2'd0;
            default:                            wen_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    // The done cycle is never an accept cycle.
                    if (cpu_en && !done_q) begin
                        if (wen_legal) begin
                            addr_q  <= cpu_addr;
                            wdata_q <= cpu_wdata;
                            wr_q    <= |cpu_wen;
                            size_q  <= (|cpu_wen) ? wen_size : cpu_rsize;
                            req_q   <= 1'b1;
                            state_q <= StReq;
                        end else begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (bus.data_addr_ok) begin
                        req_q <= 1'b0;
                        if (bus.data_data_ok) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                            if (!wr_q) rdata_q <= bus.data_rdata;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (bus.data_data_ok) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                        if (!wr_q) rdata_q <= bus.data_rdata;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_req   = req_q;
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wdata = wdata_q;

    assign cpu_rdata = rdata_q;
    assign cpu_done  = done_q;
    assign cpu_err   = err_q;
    // Gated by resetn so the pipeline is never held while the bridge is in reset.
    assign cpu_stall = resetn & ((cpu_en & (state_q == StIdle) & ~done_q) |
                                 (state_q != StIdle));

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed and randomized bench for dmem_bridge: the bench plays the memory
// and predicts bus fields, completion timing and load data from access rules.
module tb_dmem_bridge;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             cpu_en = 1'b0;
    logic [3:0]       cpu_wen = 4'b0;
    logic [1:0]       cpu_rsize = 2'd0;
    logic [WIDTH-1:0] cpu_addr = '0;
    logic [WIDTH-1:0] cpu_wdata = '0;
    logic [WIDTH-1:0] cpu_rdata;
    logic             cpu_done;
    logic             cpu_err;
    logic             cpu_stall;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_rdata = '0;

    dmem_bridge_if #(.WIDTH(WIDTH)) bus ();

    dmem_bridge #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_en    (cpu_en),
        .cpu_wen   (cpu_wen),
        .cpu_rsize (cpu_rsize),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .cpu_stall (cpu_stall),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Access rules: load, full word, aligned half, or any single byte.
    function automatic logic legal(input logic [3:0] w);
        int n;
        n = $countones(w);
        return (n == 0) || (n == 1) || (n == 4) || (w == 4'b0011) || (w == 4'b1100);
    endfunction

    function automatic logic [1:0] store_size(input logic [3:0] w);
        int n;
        n = $countones(w);
        if (n == 4) return 2'd2;
        if (n == 2) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk_fields(input string tag, input logic wr, input logic [1:0] sz,
                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] wd);
        chk({tag, "_req"}, bus.data_req, 1'b1);
        chk({tag, "_wr"}, bus.data_wr, wr);
        chk({tag, "_size"}, bus.data_size, sz);
        chk({tag, "_addr"}, bus.data_addr, a);
        chk({tag, "_wdata"}, bus.data_wdata, wd);
        chk({tag, "_stall"}, cpu_stall, 1'b1);
        chk({tag, "_done"}, cpu_done, 1'b0);
    endtask

    // Starts at posedge+1 with the bridge idle and no done pending.
    task automatic txn(input logic [3:0] wen, input logic [1:0] rsize,
                       input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] wdata,
                       input int a_dly, input int d_dly, input logic drop_en,
                       input logic [WIDTH-1:0] rd);
        logic       is_load;
        logic [1:0] esz;
        cpu_en = 1'b1; cpu_wen = wen; cpu_rsize = rsize; cpu_addr = addr; cpu_wdata = wdata;
        sample();
        chk("accept_stall", cpu_stall, 1'b1);
        chk("accept_req", bus.data_req, 1'b0);
        chk("accept_done", cpu_done, 1'b0);
        step();
        if (!legal(wen)) begin
            sample();
            chk("ill_done", cpu_done, 1'b1);
            chk("ill_err", cpu_err, 1'b1);
            chk("ill_req", bus.data_req, 1'b0);
            chk("ill_stall", cpu_stall, 1'b0);
            cpu_en = 1'b0;
            step();
            sample();
            chk("ill_done_clr", cpu_done, 1'b0);
            chk("ill_err_clr", cpu_err, 1'b0);
            chk("ill_req_after", bus.data_req, 1'b0);
            step();
        end else begin
            is_load = (wen == 4'b0000);
            esz = is_load ? rsize : store_size(wen);
            if (drop_en) cpu_en = 1'b0;
            for (int i = 0; i < a_dly; i++) begin
                bus.data_addr_ok = 1'b0;
                bus.data_data_ok = 1'($urandom % 2);
                bus.data_rdata = $urandom;
                sample();
                chk_fields("hold", !is_load, esz, addr, wdata);
                step();
            end
            bus.data_addr_ok = 1'b1;
            bus.data_data_ok = (d_dly == 0);
            bus.data_rdata = (d_dly == 0) ? rd : $urandom;
            sample();
            chk_fields("aok", !is_load, esz, addr, wdata);
            step();
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            for (int j = 1; j <= d_dly; j++) begin
                bus.data_data_ok = (j == d_dly);
                bus.data_rdata = (j == d_dly) ? rd : $urandom;
                sample();
                chk("wait_req", bus.data_req, 1'b0);
                chk("wait_stall", cpu_stall, 1'b1);
                chk("wait_done", cpu_done, 1'b0);
                step();
            end
            bus.data_data_ok = 1'b0;
            if (is_load) exp_rdata = rd;
            cpu_en = 1'($urandom % 2);
            sample();
            chk("done", cpu_done, 1'b1);
            chk("done_err", cpu_err, 1'b0);
            chk("done_rdata", cpu_rdata, exp_rdata);
            chk("done_stall", cpu_stall, 1'b0);
            chk("done_req", bus.data_req, 1'b0);
            step();
            // A request held through the done cycle must not have been taken.
            cpu_en = 1'b0;
            bus.data_data_ok = 1'b1;
            bus.data_rdata = $urandom;
            sample();
            chk("post_req", bus.data_req, 1'b0);
            chk("post_done", cpu_done, 1'b0);
            chk("post_stall", cpu_stall, 1'b0);
            step();
            bus.data_data_ok = 1'b0;
            sample();
            chk("idle_rdata", cpu_rdata, exp_rdata);
            chk("idle_done", cpu_done, 1'b0);
            step();
        end
    endtask

    logic [3:0] wen_tab [10];

    initial begin
        wen_tab = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001,
                    4'b1000, 4'b0101, 4'b0111, 4'b1001, 4'b0110};
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata = '0;
        cpu_en = 1'b1;
        cpu_wen = 4'b1111;
        cpu_addr = 32'hFFFF_FFFF;
        cpu_wdata = 32'hFFFF_FFFF;

        sample();
        chk("rst_req", bus.data_req, 1'b0);
        chk("rst_done", cpu_done, 1'b0);
        chk("rst_err", cpu_err, 1'b0);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_rdata", cpu_rdata, '0);
        chk("rst_addr", bus.data_addr, '0);
        chk("rst_wdata", bus.data_wdata, '0);
        chk("rst_size", bus.data_size, 2'd0);
        chk("rst_wr", bus.data_wr, 1'b0);
        step();
        step();
        resetn = 1'b1;
        cpu_en = 1'b0;
        sample();
        chk("idle_stall_noen", cpu_stall, 1'b0);
        step();

        txn(4'b0000, 2'd2, 32'h0000_1000, 32'h0, 0, 2, 1'b0, 32'hDEAD_BEEF);
        txn(4'b0100, 2'd3, 32'h0000_2002, 32'h00AB_0000, 0, 1, 1'b0, 32'h1234_5678);
        txn(4'b1100, 2'd0, 32'h0000_3002, 32'hCAFE_0000, 1, 1, 1'b1, 32'h0);
        txn(4'b0101, 2'd2, 32'h0000_4000, 32'h0, 0, 0, 1'b0, 32'h0);
        txn(4'b1111, 2'd0, 32'h0000_5000, 32'h0BAD_F00D, 5, 0, 1'b0, 32'h0);
        txn(4'b0000, 2'd1, 32'h0000_6002, 32'h0, 0, 0, 1'b1, 32'h0000_BEEF);

        for (int k = 0; k < 80; k++) begin
            txn(wen_tab[$urandom % 10], 2'($urandom % 3), $urandom, $urandom,
                int'($urandom % 4), int'($urandom % 4), 1'($urandom % 2), $urandom);
        end

        // Reset while the access sits in WAIT.
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_rsize = 2'd2; cpu_addr = 32'h0000_7000;
        step();
        bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0;
        sample();
        chk("rw_wait_stall", cpu_stall, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        exp_rdata = '0;
        chk("rw_req", bus.data_req, 1'b0);
        chk("rw_stall", cpu_stall, 1'b0);
        chk("rw_done", cpu_done, 1'b0);
        chk("rw_rdata", cpu_rdata, exp_rdata);
        chk("rw_addr", bus.data_addr, '0);
        step();
        resetn = 1'b1;
        cpu_en = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata = 32'h5555_AAAA;
        sample();
        chk("rw_ok_done", cpu_done, 1'b0);
        step();
        bus.data_data_ok = 1'b0;
        sample();
        chk("rw_after_done", cpu_done, 1'b0);
        chk("rw_after_rdata", cpu_rdata, exp_rdata);
        chk("rw_after_stall", cpu_stall, 1'b0);
        step();

        txn(4'b0000, 2'd2, 32'h0000_8000, 32'h0, 2, 1, 1'b0, 32'h0F0F_F0F0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the address and data width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port cpu_en, input, 1 bit: MEM-stage access request, held until cpu_done.
REQ-005 The module SHALL have port cpu_wen, input, 4 bits: filtered byte-enable; 4'b0000 means load.
REQ-006 The module SHALL have port cpu_rsize, input, 2 bits: load size (0 byte, 1 half, 2 word); ignored for stores.
REQ-007 The module SHALL have port cpu_addr, input, WIDTH bits: byte address.
REQ-008 The module SHALL have port cpu_wdata, input, WIDTH bits: store data, already lane-aligned.
REQ-009 The module SHALL have port cpu_rdata, output, WIDTH bits: load data, registered.
REQ-010 The module SHALL have port cpu_done, output, 1 bit: one-cycle completion pulse.
REQ-011 The module SHALL have port cpu_err, output, 1 bit: one-cycle illegal byte-enable pulse, coincident with cpu_done.
REQ-012 The module SHALL have port cpu_stall, output, 1 bit: pipeline hold request.
REQ-013 The module SHALL have the following bus ports: data_req (output, 1), data_wr (output, 1), data_size (output, 2), data_addr (output, WIDTH), data_wdata (output, WIDTH), data_addr_ok (input, 1), data_data_ok (input, 1), data_rdata (input, WIDTH).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, REQ (data_req high, awaiting data_addr_ok), WAIT (awaiting data_data_ok).
REQ-015 In IDLE with cpu_en=1 and a legal cpu_wen, the module SHALL capture addr, wdata, wen and size into registers on that edge and SHALL move to REQ.
REQ-016 For legal cpu_wen, stores SHALL derive data_size: 1111->2; 0011 or 1100->1; 0001, 0010, 0100 or 1000->0. For loads, data_size SHALL equal cpu_rsize.
REQ-017 Any other nonzero cpu_wen SHALL be illegal: no bus request; cpu_done=1 and cpu_err=1 on the next cycle; state SHALL stay IDLE.
REQ-018 In REQ, data_req SHALL be 1, and data_wr, data_size, data_addr and data_wdata SHALL be driven from the captured registers and held stable until data_addr_ok.
REQ-019 In REQ with data_addr_ok=1, the FSM SHALL go to WAIT and data_req SHALL drop the next cycle.
REQ-020 If data_data_ok=1 in the same cycle as data_addr_ok=1, the FSM SHALL complete directly to IDLE.
REQ-021 In WAIT with data_data_ok=1, the FSM SHALL go to IDLE, SHALL pulse cpu_done the next cycle, and for loads SHALL register data_rdata into cpu_rdata.
REQ-022 data_data_ok SHALL be ignored in IDLE, and in REQ without data_addr_ok.
REQ-023 cpu_rdata SHALL hold its value until the next load completion; stores SHALL NOT modify it.
REQ-024 cpu_stall SHALL be (cpu_en and IDLE and cpu_done=0) or state!=IDLE.
REQ-025 In the cycle cpu_done=1 the module SHALL NOT accept a new request, even with cpu_en=1; minimum spacing between accesses is therefore 2 cycles idle-to-idle.
REQ-026 Dropping cpu_en while in REQ or WAIT SHALL NOT abort the access; the bus transaction SHALL complete and cpu_done SHALL still pulse.
REQ-027 Minimum latency, from accept to cpu_done, SHALL be 2 cycles (addr_ok and data_ok both in the first REQ cycle).

Reset
REQ-028 While resetn=0, the FSM SHALL be forced to IDLE immediately.
REQ-029 While resetn=0, data_req, cpu_done, cpu_err and cpu_stall SHALL be 0.
REQ-030 While resetn=0, cpu_rdata, data_addr, data_wdata, data_size and data_wr SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon the access with no cpu_done pulse, and SHALL ignore data_data_ok arriving after resetn deasserts.

Verification
REQ-032 Scenario, word load: cpu_en=1, wen=0000, rsize=2, addr=0x1000; addr_ok on cycle 1, data_ok=1 with rdata=0xDEADBEEF on cycle 3 -> data_size=2, data_wr=0, cpu_done on cycle 4, cpu_rdata=0xDEADBEEF, stall low on cycle 4.
REQ-033 Scenario, byte store: wen=0100, addr=0x2002, wdata=0x00AB0000 -> data_wr=1, data_size=0, data_addr=0x2002, data_wdata=0x00AB0000; cpu_rdata unchanged after done.
REQ-034 Scenario, half store: wen=1100 -> data_size=1.
REQ-035 Scenario, illegal enable: wen=0101 -> data_req never asserts; cpu_done=1 and cpu_err=1 for exactly one cycle.
REQ-036 Scenario, back-pressure: addr_ok withheld 5 cycles -> data_req and all bus fields stable for 5 cycles, stall high throughout; addr_ok and data_ok in the same cycle -> done on the next cycle, total latency 2.
REQ-037 Scenario, reset in WAIT: resetn low in WAIT -> data_req=0, cpu_stall=0, no cpu_done; a subsequent data_ok pulse is ignored.
